uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive stage of the UART. It oversamples the RX line 16x, detects and validates start bits, and shifts in 5–8 data bits LSB-first. It checks the optional parity bit and one or two stop bits. It presents each received character with its frame and parity status to the main controller and RX FIFO, using a one-cycle `rx_done_o` pulse.

## Interface
Parameters:
- `OVERSAMPLE`, 16, ticks per bit period; must be a power of two ≥ 8.

Ports:
- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  asynchronous active-low reset
- `ov_baud_rt_i`  in  1  oversample tick, one-cycle pulse at OVERSAMPLE × baud
- `rx_i`  in  1  asynchronous serial line, idle high
- `rx_enable_i`  in  1  receiver enable
- `data_width_i`  in  2  00=5, 01=6, 10=7, 11=8 data bits
- `parity_mode_i`  in  2  00/11 = none, 01 = even, 10 = odd
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits
- `data_rx_o`  out  8  received character, right-aligned, unused MSBs zero
- `rx_done_o`  out  1  one-cycle pulse when a character completes
- `frame_error_o`  out  1  a stop bit was sampled low
- `parity_error_o`  out  1  parity check failed
- `rx_busy_o`  out  1  a frame is in progress (state ≠ IDLE)

## Operation
- `rx_i` passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- Configuration inputs are sampled into shadow registers on the START→DATA transition. Changes mid-frame have no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE. A tick counter (log2 OVERSAMPLE bits) advances only on `ov_baud_rt_i`.
- **IDLE**
  - Waits for a falling edge of `rx_s` with `rx_enable_i` = 1.
  - On that edge: clear the tick counter and go to START.
- **START**
  - At tick OVERSAMPLE/2 − 1 (bit centre), sample `rx_s`.
  - If low: clear the tick and bit counters, then go to DATA.
  - If high: treat it as a glitch and return to IDLE with no pulse.
- **DATA**
  - Every OVERSAMPLE ticks (the counter wraps at OVERSAMPLE − 1), sample `rx_s` into the shift register at index `bit_cnt`, LSB first.
  - After the last bit (`bit_cnt` = width − 1), go to PARITY if parity is enabled, else STOP.
- **PARITY**
  - Sample one bit.
  - Even parity: error if the XOR of the data bits and the parity bit is 1.
  - Odd parity: error if that XOR is 0.
- **STOP**
  - Sample one bit, or two bits when `stop_bits_i` = 1.
  - Any low sample sets the internal frame error; there is no early exit.
  - After the last stop sample, go to DONE.
- **DONE** (one cycle)
  - Load `data_rx_o`, `frame_error_o` and `parity_error_o` from the internal values.
  - Assert `rx_done_o`, then return to IDLE.
- Output holding:
  - `data_rx_o` and both error flags hold until the next DONE.
  - When parity is disabled, `parity_error_o` is always 0.
- Aborts:
  - `rx_enable_i` deasserted in any non-IDLE state: abort to IDLE on the next cycle. No `rx_done_o`; outputs keep their previous values.
  - Reset asserted mid-frame: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - `data_rx_o` = 0x00; `rx_done_o`, `frame_error_o`, `parity_error_o`, `rx_busy_o` = 0.
  - FSM = IDLE; counters = 0; synchronizer = 1.
- Start detection occurs 2 clocks after `rx_i` falls (synchronizer latency).
- The falling edge is checked every clock, not only on ticks. The first tick after START entry is counted as tick 0.
- Each data, parity and stop sample is taken in the clock where `ov_baud_rt_i` = 1 and the tick counter = OVERSAMPLE/2 − 1, measured relative to the START sample point.
- `rx_done_o` asserts exactly 1 clock after the clock holding the final stop-bit sample tick. It is high for exactly 1 clock.
- `rx_busy_o` is high from the cycle after START entry through the DONE cycle inclusive.
- Back-to-back frames: a falling edge is accepted in the first IDLE cycle after DONE. There is no dead time beyond the DONE cycle.
- Frame error with a line still low after the stop bit (break): the block reports DONE. It then re-enters START only on a new falling edge, so a held-low line does not retrigger.

## Test plan
- 8N1, tick every clock, send 0xA5:
  - Required: `rx_done_o` pulse, `data_rx_o` = 0xA5, both error flags 0.
  - Done arrives 2 + 8 + 16×9 clocks (±1) after the falling edge.
- 7E1, send 0x35 with correct parity 0:
  - Required: `data_rx_o` = 0x35, `parity_error_o` = 0.
  - Repeat with parity bit 1: `parity_error_o` = 1, data still 0x35.
- 5O2, send 0x1F with the second stop bit forced low:
  - Required: `data_rx_o` = 0x1F, `frame_error_o` = 1.
  - The next clean frame 0x0A clears `frame_error_o` to 0.
- Glitch rejection: drive `rx_i` low for 3 ticks, then high.
  - Required: no `rx_done_o`, `rx_busy_o` returns to 0, FSM in IDLE.
- Abort:
  - Deassert `rx_enable_i` during data bit 3 of 0x5A.
    - Required: no done pulse, outputs unchanged from the previous frame.
  - Assert `rst_n_i` mid-frame instead.
    - Required: all outputs 0 immediately.
- Back-to-back 8N1 frames 0x00 and 0xFF with no idle gap:
  - Required: two done pulses with correct data.
  - `frame_error_o` stays 0.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive stage.
// Start-bit validation, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Each completed character is presented with a one-cycle rx_done_o pulse.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic       rx_enable_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic       stop_bits_i,
  output logic [7:0] data_rx_o,
  output logic       rx_done_o,
  output logic       frame_error_o,
  output logic       parity_error_o,
  output logic       rx_busy_o
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    width_q, width_d;
  logic [1:0]    par_mode_q, par_mode_d;
  logic          stop2_q, stop2_d;
  logic          fe_q, fe_d, pe_q, pe_d;
  logic [7:0]    data_q, data_d;
  logic          fe_o_q, fe_o_d, pe_o_q, pe_o_d;

  // Parity is enabled only for modes 01 (even) and 10 (odd).
  logic par_en, par_odd, par_x, samp;
  assign par_en  = parity_mode_q_en(par_mode_q);
  assign par_odd = (par_mode_q == 2'b10);
  assign par_x   = (^shift_q) ^ rx_s_q;
  // Mid-bit sample point; the START phase counts half a bit, later phases a full bit.
  assign samp    = ov_baud_rt_i && (tick_q == ((state_q == START) ? HALF : LAST));

  function automatic logic parity_mode_q_en(input logic [1:0] m);
    return m[0] ^ m[1];
  endfunction

  // Two-flop synchronizer plus edge-history flop; idle-high on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State, counters, frame shadows and held outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      width_q    <= '0;
      par_mode_q <= '0;
      stop2_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      data_q     <= '0;
      fe_o_q     <= 1'b0;
      pe_o_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      width_q    <= width_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      data_q     <= data_d;
      fe_o_q     <= fe_o_d;
      pe_o_q     <= pe_o_d;
    end
  end

  // Next-state logic; outputs are loaded on entry to DONE so they are valid with the pulse.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    width_d    = width_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    data_d     = data_q;
    fe_o_d     = fe_o_q;
    pe_o_d     = pe_o_q;
    if (state_q != IDLE && state_q != DONE && ov_baud_rt_i) tick_d = tick_q + TW'(1);
    case (state_q)
      IDLE: if (rx_enable_i && rx_prev_q && !rx_s_q) begin
        state_d = START;
        tick_d  = '0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
      end
      START: if (samp) begin
        if (!rx_s_q) begin
          state_d    = DATA;
          tick_d     = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          width_d    = data_width_i;
          par_mode_d = parity_mode_i;
          stop2_d    = stop_bits_i;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (samp) begin
        shift_d[bit_cnt_q] = rx_s_q;
        if (bit_cnt_q == {1'b1, width_q}) begin
          bit_cnt_d = '0;
          state_d   = par_en ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: if (samp) begin
        pe_d    = par_odd ? ~par_x : par_x;
        state_d = STOP;
      end
      STOP: if (samp) begin
        fe_d = fe_q | ~rx_s_q;
        if (bit_cnt_q == {2'b00, stop2_q}) begin
          state_d = DONE;
          data_d  = shift_q;
          fe_o_d  = fe_q | ~rx_s_q;
          pe_o_d  = pe_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Disable aborts any frame in flight without touching the presented character.
    if (state_q != IDLE && !rx_enable_i) begin
      state_d = IDLE;
      data_d  = data_q;
      fe_o_d  = fe_o_q;
      pe_o_d  = pe_o_q;
    end
  end

  assign data_rx_o      = data_q;
  assign frame_error_o  = fe_o_q;
  assign parity_error_o = pe_o_q;
  assign rx_done_o      = (state_q == DONE);
  assign rx_busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames plus hand-written corner sequences.
module tb_uart_receiver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       rx = 1'b1;
  logic       en = 1'b1;
  logic [1:0] dw = 2'd3, pm = 2'd0;
  logic       sb = 1'b0;
  logic [7:0] data;
  logic       done, fe, pe, busy;

  uart_receiver #(.OVERSAMPLE(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ov_baud_rt_i(tick), .rx_i(rx),
    .rx_enable_i(en), .data_width_i(dw), .parity_mode_i(pm), .stop_bits_i(sb),
    .data_rx_o(data), .rx_done_o(done), .frame_error_o(fe),
    .parity_error_o(pe), .rx_busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: one tick every 'div' clocks.
  int div = 1;
  int tdiv = 0;
  initial forever begin
    @(negedge clk);
    tdiv = tdiv + 1;
    tick = ((tdiv % div) == 0);
  end

  // Done-pulse monitor: counts pulses, captures outputs, flags pulses wider than one clock.
  int done_cnt = 0, done_cyc = 0, dbl = 0;
  logic prev_done = 1'b0;
  logic [7:0] hd [4];
  logic       hf [4];
  always @(negedge clk) begin
    if (done) begin
      hd[done_cnt % 4] = data;
      hf[done_cnt % 4] = fe;
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (prev_done) dbl = dbl + 1;
    end
    prev_done = done;
  end

  int vecs_applied = 0, miscompares = 0;
  int fall_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (16 * div - 1) @(negedge clk);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [1:0] w, input logic [1:0] par, input logic stp,
                            input logic [7:0] din, input logic flip, input logic [1:0] slow,
                            input logic keep_low);
    logic [7:0] m;
    logic p;
    m = 8'hFF >> (3 - w);
    @(negedge clk);
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (16 * div - 1) @(negedge clk);
    for (int i = 0; i < 5 + int'(w); i++) put_bit(din[i]);
    if (par == 2'b01 || par == 2'b10) begin
      p = ^(din & m);
      if (par == 2'b10) p = ~p;
      put_bit(p ^ flip);
    end
    put_bit(~slow[0]);
    if (stp) put_bit(~slow[1]);
    @(negedge clk);
    rx = ~keep_low;
  endtask

  typedef struct {
    logic [1:0] w;
    logic [1:0] par;
    logic       stp;
    logic [7:0] din;
    logic       flip;
    logic [1:0] slow;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs [9];
  int c0;

  initial begin
    vecs[0] = '{2'd3, 2'd0, 1'b0, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0}; // 8N1
    vecs[1] = '{2'd2, 2'd1, 1'b0, 8'h35, 1'b0, 2'b00, 8'h35, 1'b0, 1'b0}; // 7E1 good
    vecs[2] = '{2'd2, 2'd1, 1'b0, 8'h35, 1'b1, 2'b00, 8'h35, 1'b0, 1'b1}; // 7E1 bad parity
    vecs[3] = '{2'd0, 2'd2, 1'b1, 8'h1F, 1'b0, 2'b10, 8'h1F, 1'b1, 1'b0}; // 5O2 2nd stop low
    vecs[4] = '{2'd0, 2'd2, 1'b1, 8'h0A, 1'b0, 2'b00, 8'h0A, 1'b0, 1'b0}; // 5O2 clean
    vecs[5] = '{2'd1, 2'd0, 1'b1, 8'h2C, 1'b0, 2'b00, 8'h2C, 1'b0, 1'b0}; // 6N2
    vecs[6] = '{2'd0, 2'd3, 1'b0, 8'hFF, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0}; // 5N1, MSBs zero
    vecs[7] = '{2'd3, 2'd0, 1'b0, 8'h3C, 1'b0, 2'b01, 8'h3C, 1'b1, 1'b0}; // 8N1 stop low
    vecs[8] = '{2'd3, 2'd2, 1'b0, 8'h80, 1'b1, 2'b00, 8'h80, 1'b0, 1'b1}; // 8O1 bad parity

    wait_clk(3);
    chk("reset_data", data, 8'h00);
    chk("reset_flags", {done, fe, pe, busy}, 4'b0000);
    rst_n = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 9; i++) begin
      dw = vecs[i].w; pm = vecs[i].par; sb = vecs[i].stp;
      c0 = done_cnt;
      send_frame(vecs[i].w, vecs[i].par, vecs[i].stp, vecs[i].din, vecs[i].flip, vecs[i].slow, 1'b0);
      wait_clk(32);
      chk($sformatf("v%0d_done", i), done_cnt - c0, 1);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_d);
      chk($sformatf("v%0d_fe", i), fe, vecs[i].exp_fe);
      chk($sformatf("v%0d_pe", i), pe, vecs[i].exp_pe);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      if (i == 0) chk("v0_latency", done_cyc - fall_cyc - 1 inside {[153:155]}, 1);
    end

    // Glitch: three clocks low, then back high.
    dw = 2'd3; pm = 2'd0; sb = 1'b0;
    c0 = done_cnt;
    @(negedge clk); rx = 1'b0;
    wait_clk(3); rx = 1'b1;
    wait_clk(2);
    chk("glitch_busy_mid", busy, 1'b1);
    wait_clk(40);
    chk("glitch_no_done", done_cnt - c0, 0);
    chk("glitch_idle", busy, 1'b0);

    // Enable dropped during data bit 3 of 0x5A.
    c0 = done_cnt;
    fork
      send_frame(2'd3, 2'd0, 1'b0, 8'h5A, 1'b0, 2'b00, 1'b0);
      begin
        wait_clk(70);
        chk("abort_busy_mid", busy, 1'b1);
        en = 1'b0;
      end
    join
    wait_clk(20);
    en = 1'b1;
    wait_clk(5);
    chk("abort_no_done", done_cnt - c0, 0);
    chk("abort_data_held", data, 8'h80);
    chk("abort_flags_held", {fe, pe, busy}, 3'b010);

    // Reset mid-frame clears outputs immediately.
    c0 = done_cnt;
    fork
      send_frame(2'd3, 2'd0, 1'b0, 8'h5A, 1'b0, 2'b00, 1'b0);
      begin
        wait_clk(70);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_flags", {done, fe, pe, busy}, 4'b0000);
      end
    join
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(20);
    chk("rst_no_done", done_cnt - c0, 0);

    // Back-to-back 8N1 frames with no idle gap.
    c0 = done_cnt;
    send_frame(2'd3, 2'd0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
    send_frame(2'd3, 2'd0, 1'b0, 8'hFF, 1'b0, 2'b00, 1'b0);
    wait_clk(32);
    chk("b2b_count", done_cnt - c0, 2);
    chk("b2b_d0", hd[c0 % 4], 8'h00);
    chk("b2b_d1", hd[(c0 + 1) % 4], 8'hFF);
    chk("b2b_fe", {hf[c0 % 4], hf[(c0 + 1) % 4]}, 2'b00);

    // Slower tick rate: one tick every two clocks.
    div = 2;
    c0 = done_cnt;
    send_frame(2'd3, 2'd0, 1'b0, 8'hC3, 1'b0, 2'b00, 1'b0);
    wait_clk(64);
    chk("div2_done", done_cnt - c0, 1);
    chk("div2_data", data, 8'hC3);
    div = 1;
    wait_clk(4);

    // Break: stop bit low and line held low; reports once, no retrigger.
    c0 = done_cnt;
    send_frame(2'd3, 2'd0, 1'b0, 8'h55, 1'b0, 2'b01, 1'b1);
    wait_clk(48);
    chk("break_done", done_cnt - c0, 1);
    chk("break_fe", fe, 1'b1);
    chk("break_idle", busy, 1'b0);
    @(negedge clk); rx = 1'b1;
    wait_clk(32);
    chk("break_no_retrig", done_cnt - c0, 1);

    chk("pulse_width", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
    $finish;
  end
endmodule
